// File: rtl/seq_alu_pipe_if.sv
// seq_alu_pipe_if: operand issue / result writeback bundle for seq_alu_pipe.
// Optional y_hi signal present only when SEQ_ALU_WIDE_RESULT_EN is defined.
interface seq_alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             zero;
  logic             div_zero;
`ifdef SEQ_ALU_WIDE_RESULT_EN
  logic [WIDTH-1:0] y_hi;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, y, carry, zero, div_zero, y_hi
  );
  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, y, carry, zero, div_zero, y_hi
  );
`else
  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, y, carry, zero, div_zero
  );
  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, y, carry, zero, div_zero
  );
`endif
endinterface

// File: rtl/seq_alu_pipe.sv
// seq_alu_pipe: handshaked sequential ALU. Single-cycle ADD/SUB/logic ops,
// iterative shift-add MUL and restoring DIV (one bit per cycle, WIDTH cycles).
// Optional macro SEQ_ALU_WIDE_RESULT_EN adds y_hi (product high half / remainder).
module seq_alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  seq_alu_pipe_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand for MUL, divisor for DIV
  logic [2*WIDTH-1:0] prod_q, prod_d;     // MUL: {acc, multiplier}; DIV: {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   y_hi_q, y_hi_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               div_zero_q, div_zero_d;

  logic               accept;
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   fast_y;
  logic               fast_carry;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] step;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign add_full = {1'b0, bus.a} + {1'b0, bus.b};

  // One iteration of the selected engine, computed from the working register
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
  assign div_shift = prod_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign step = (sel_q == OP_MUL)
              ? {mul_sum, prod_q[WIDTH-1:1]}
              : {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                 prod_q[WIDTH-2:0], ~div_trial[WIDTH]};

  // Results of the single-cycle ops, taken straight from the bus at accept
  always_comb begin
    fast_y     = '0;
    fast_carry = 1'b0;
    case (bus.sel)
      OP_ADD: begin fast_y = add_full[WIDTH-1:0]; fast_carry = add_full[WIDTH]; end
      OP_SUB: begin fast_y = bus.a - bus.b;       fast_carry = (bus.a < bus.b); end
      OP_AND: fast_y = bus.a & bus.b;
      OP_OR:  fast_y = bus.a | bus.b;
      OP_XOR: fast_y = bus.a ^ bus.b;
      3'b111: fast_y = ~bus.a;
      default: ;
    endcase
  end

  // Next-state and datapath updates; outputs hold unless a result is produced
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    opnd_d     = opnd_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    y_hi_d     = y_hi_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = bus.sel;
          cnt_d = '0;
          if (bus.sel == OP_MUL) begin
            opnd_d  = bus.a;
            prod_d  = {{WIDTH{1'b0}}, bus.b};
            state_d = BUSY;
          end else if (bus.sel == OP_DIV && bus.b != '0) begin
            opnd_d  = bus.b;
            prod_d  = {{WIDTH{1'b0}}, bus.a};
            state_d = BUSY;
          end else if (bus.sel == OP_DIV) begin
            // Divide by zero: skip the engine, report y=0 and remainder=a
            y_d        = '0;
            y_hi_d     = bus.a;
            carry_d    = 1'b0;
            zero_d     = 1'b1;
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            y_d        = fast_y;
            y_hi_d     = '0;
            carry_d    = fast_carry;
            zero_d     = (fast_y == '0);
            div_zero_d = 1'b0;
            state_d    = DONE;
          end
        end
      end
      BUSY: begin
        prod_d = step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          y_d        = step[WIDTH-1:0];
          y_hi_d     = step[2*WIDTH-1:WIDTH];
          carry_d    = (sel_q == OP_MUL) && (|step[2*WIDTH-1:WIDTH]);
          zero_d     = (step[WIDTH-1:0] == '0);
          div_zero_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      opnd_q     <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      y_q        <= '0;
      y_hi_q     <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      opnd_q     <= opnd_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      y_q        <= y_d;
      y_hi_q     <= y_hi_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.y         = y_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.div_zero  = div_zero_q;
`ifdef SEQ_ALU_WIDE_RESULT_EN
  assign bus.y_hi      = y_hi_q;
`else
  logic unused_y_hi;
  assign unused_y_hi = ^y_hi_q;
`endif
endmodule

// File: tb/tb_seq_alu_pipe.sv
// tb_seq_alu_pipe: directed-vector bench for seq_alu_pipe (WIDTH=8).
// Covers y_hi too when SEQ_ALU_WIDE_RESULT_EN is defined.
module tb_seq_alu_pipe;
  logic clk;
  logic rst_n;
  int   checks_cnt;
  int   errors_cnt;

  seq_alu_pipe_if #(.WIDTH(8)) bus ();

  seq_alu_pipe #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op (called at posedge+1 with the DUT idle), wait for the result,
  // check latency and all result fields, then complete the handshake.
  task automatic do_op(input string tag, input logic [2:0] s, input logic [7:0] av,
                       input logic [7:0] bv, input int exp_lat, input logic [7:0] ey,
                       input logic ec, input logic ez, input logic edz, input logic [7:0] eyhi);
    int lat;
    bus.sel       = s;
    bus.a         = av;
    bus.b         = bv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_y"}, bus.y, ey);
    check_eq({tag, "_carry"}, bus.carry, ec);
    check_eq({tag, "_zero"}, bus.zero, ez);
    check_eq({tag, "_divzero"}, bus.div_zero, edz);
    check_eq({tag, "_inready_busy"}, bus.in_ready, 0);
`ifdef SEQ_ALU_WIDE_RESULT_EN
    check_eq({tag, "_yhi"}, bus.y_hi, eyhi);
`endif
    $display("txn %s sel=%0d a=0x%02h b=0x%02h lat=%0d y=0x%02h c=%0b z=%0b dz=%0b (yhi exp 0x%02h)",
             tag, s, av, bv, lat, bus.y, bus.carry, bus.zero, bus.div_zero, eyhi);
    @(posedge clk);
    #1;
    check_eq({tag, "_inready_after"}, bus.in_ready, 1);
  endtask

  initial begin
    logic [2:0] bb_s [3];
    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];
    logic [7:0] bb_y [3];
    int         seen;
    int         idx;
    int         res;
    int         last_acc;
    logic       rdy;
    logic       vld;

    checks_cnt    = 0;
    errors_cnt    = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.sel       = 3'b000;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_y", bus.y, 0);
    check_eq("rst_carry", bus.carry, 0);
    check_eq("rst_zero", bus.zero, 0);
    check_eq("rst_divzero", bus.div_zero, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", bus.in_ready, 1);

    // Single-cycle arithmetic
    do_op("add_f0_20", 3'b000, 8'hF0, 8'h20, 1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00);
    do_op("sub_05_07", 3'b001, 8'h05, 8'h07, 1, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h00);
    do_op("sub_09_09", 3'b001, 8'h09, 8'h09, 1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    do_op("add_12_34", 3'b000, 8'h12, 8'h34, 1, 8'h46, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of a MUL (200*3), during BUSY cycle 4
    do_op("add_ff_11", 3'b000, 8'hFF, 8'h11, 1, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00);
    bus.sel      = 3'b010;
    bus.a        = 8'd200;
    bus.b        = 8'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midmul_out_valid", bus.out_valid, 0);
    check_eq("midmul_y", bus.y, 0);
    check_eq("midmul_carry", bus.carry, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("midmul_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check_eq("midmul_no_result", seen, 0);
    $display("txn midmul_reset spurious_results=%0d", seen);
    @(posedge clk);
    #1;

    // Multi-cycle MUL / DIV
    do_op("mul_20_13", 3'b010, 8'd20, 8'd13, 9, 8'h04, 1'b1, 1'b0, 1'b0, 8'h01);
    do_op("mul_200_3", 3'b010, 8'd200, 8'd3, 9, 8'h58, 1'b1, 1'b0, 1'b0, 8'h02);
    do_op("mul_15_17", 3'b010, 8'd15, 8'd17, 9, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
    do_op("div_100_7", 3'b011, 8'd100, 8'd7, 9, 8'd14, 1'b0, 1'b0, 1'b0, 8'd2);
    do_op("div_7_100", 3'b011, 8'd7, 8'd100, 9, 8'd0, 1'b0, 1'b1, 1'b0, 8'd7);
    do_op("div_255_16", 3'b011, 8'd255, 8'd16, 9, 8'd15, 1'b0, 1'b0, 1'b0, 8'd15);
    do_op("div_55_0", 3'b011, 8'd55, 8'd0, 1, 8'd0, 1'b0, 1'b1, 1'b1, 8'd55);

    // Backpressure: XOR 0xAA^0xAA held for 5 cycles, in_valid pulses ignored
    bus.sel       = 3'b110;
    bus.a         = 8'hAA;
    bus.b         = 8'hAA;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_first_valid", bus.out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (k % 2 == 0);
      bus.sel      = 3'b000;
      bus.a        = 8'h0F;
      bus.b        = 8'h01;
      @(negedge clk);
      check_eq("bp_out_valid", bus.out_valid, 1);
      check_eq("bp_y", bus.y, 0);
      check_eq("bp_zero", bus.zero, 1);
      check_eq("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_released_valid", bus.out_valid, 0);
    check_eq("bp_released_ready", bus.in_ready, 1);
    $display("txn backpressure xor_aa_aa y=0x%02h z=%0b", bus.y, bus.zero);

    // Back-to-back stream with in_valid held high
    bb_s[0] = 3'b100; bb_a[0] = 8'hCC; bb_b[0] = 8'hAA; bb_y[0] = 8'h88;
    bb_s[1] = 3'b101; bb_a[1] = 8'h0C; bb_b[1] = 8'h30; bb_y[1] = 8'h3C;
    bb_s[2] = 3'b111; bb_a[2] = 8'h5A; bb_b[2] = 8'hFF; bb_y[2] = 8'hA5;
    idx      = 0;
    res      = 0;
    last_acc = -1;
    bus.sel      = bb_s[0];
    bus.a        = bb_a[0];
    bus.b        = bb_b[0];
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20 && res < 3; c++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      vld = bus.in_valid;
      if (bus.out_valid) begin
        check_eq("bb_y", bus.y, (res < 3) ? {24'h0, bb_y[res]} : 32'h0);
        $display("txn bb result %0d y=0x%02h", res, bus.y);
        res++;
      end
      @(posedge clk);
      #1;
      if (rdy && vld) begin
        if (last_acc >= 0) check_eq("bb_spacing", c - last_acc, 2);
        last_acc = c;
        idx++;
        if (idx < 3) begin
          bus.sel = bb_s[idx];
          bus.a   = bb_a[idx];
          bus.b   = bb_b[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    check_eq("bb_count", res, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
